// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and sizing helpers for the FIFO write-arbiter controller
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_SIZE  = 8;
  localparam int DEPTH      = 2 ** ADDR_SIZE;
  localparam int NUM_REQ    = 4;

  // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than a pointer.
  function automatic int count_width(input int addr_size);
    return addr_size + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_if.sv
// rtl/fifo_wr_arb_ctrl_if.sv - requester, consumer and storage-side signals of the FIFO controller
interface fifo_wr_arb_ctrl_if
  import fifo_pkg::*;
#(
  parameter int num_req_p    = NUM_REQ,
  parameter int data_width_p = DATA_WIDTH,
  parameter int addr_size_p  = ADDR_SIZE
) ();

  logic [num_req_p-1:0]              req;
  logic [num_req_p*data_width_p-1:0] req_data;
  logic [num_req_p-1:0]              gnt;
  logic                              rd_req;
  logic                              rd_valid;
  logic                              mem_wr_en;
  logic [data_width_p-1:0]           mem_data_in;
  logic [addr_size_p-1:0]            mem_b_w_ptr;
  logic                              mem_rd_en;
  logic [addr_size_p-1:0]            mem_b_r_ptr;
  logic                              full;
  logic                              empty;
  logic                              almost_full;
  logic                              almost_empty;
  logic [addr_size_p:0]              count;
  logic                              overflow;
  logic                              underflow;

  modport master (
    output req, req_data, rd_req,
    input  gnt, rd_valid, mem_wr_en, mem_data_in, mem_b_w_ptr, mem_rd_en, mem_b_r_ptr,
    input  full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  req, req_data, rd_req,
    output gnt, rd_valid, mem_wr_en, mem_data_in, mem_b_w_ptr, mem_rd_en, mem_b_r_ptr,
    output full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int num_req_p = NUM_REQ
) (
  input  logic [num_req_p-1:0]            req,
  input  logic [idx_width(num_req_p)-1:0] rr_ptr,
  output logic [num_req_p-1:0]            gnt,
  output logic [idx_width(num_req_p)-1:0] winner
);

  localparam int IW = idx_width(num_req_p);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = (int'(rr_ptr) + k) % num_req_p;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// rtl/fifo_wr_arb_ctrl.sv - FIFO controller: round-robin write port sharing, pointers, count and flags
module fifo_wr_arb_ctrl
  import fifo_pkg::*;
#(
  parameter int data_width_p = DATA_WIDTH,
  parameter int addr_size_p  = ADDR_SIZE,
  parameter int num_req_p    = NUM_REQ,
  parameter int af_level_p   = 240,
  parameter int ae_level_p   = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arb_ctrl_if.slave  bus
);

  localparam int CW = count_width(addr_size_p);
  localparam int IW = idx_width(num_req_p);
  localparam logic [CW-1:0] DEPTH_C = CW'(1) << addr_size_p;

  logic [num_req_p-1:0]   arb_req;
  logic [num_req_p-1:0]   gnt;
  logic [IW-1:0]          winner;
  logic [IW-1:0]          rr_ptr;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [addr_size_p-1:0] wptr;
  logic [addr_size_p-1:0] rptr;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_next;
  logic                   full_q, empty_q, af_q, ae_q;
  logic                   rd_valid_q, overflow_q, underflow_q;

  // Full masks every request, so a write at full can never be granted.
  assign arb_req = (rst || full_q) ? '0 : bus.req;

  rr_arbiter #(.num_req_p(num_req_p)) u_rr_arbiter (
    .req    (arb_req),
    .rr_ptr (rr_ptr),
    .gnt    (gnt),
    .winner (winner)
  );

  assign wr_acc = |gnt;
  assign rd_acc = bus.rd_req & ~empty_q & ~rst;

  always_comb begin
    count_next = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      rr_ptr      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr   <= wptr + 1'b1;
        rr_ptr <= (winner == IW'(num_req_p - 1)) ? '0 : winner + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
      end
      count_q    <= count_next;
      full_q     <= (count_next == DEPTH_C);
      empty_q    <= (count_next == '0);
      af_q       <= (count_next >= CW'(af_level_p));
      ae_q       <= (count_next <= CW'(ae_level_p));
      rd_valid_q <= rd_acc;
      if (|bus.req && full_q) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_req && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.gnt          = gnt;
  assign bus.mem_wr_en    = wr_acc;
  assign bus.mem_data_in  = bus.req_data[int'(winner)*data_width_p +: data_width_p];
  assign bus.mem_b_w_ptr  = wptr;
  assign bus.mem_rd_en    = rd_acc;
  assign bus.mem_b_r_ptr  = rptr;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
